// File: rtl/cfu_initiator.sv
// -----------------------------------------------------------------------------
// cfu_initiator
//
// Queues host commands for a custom function unit (CFU), issues them one at a
// time over a valid/ready command channel, waits for the CFU response with a
// bounded timeout, and queues the responses for the host.
//
// Ports
//   clk, reset                 clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready        host command push handshake
//   req_function_id, req_in0/1 host command contents
//   cmd_valid/cmd_ready        command channel to the CFU
//   cmd_payload_*              issued command (held stable while cmd_valid=1)
//   rsp_valid/rsp_ready        response channel from the CFU
//   rsp_payload_outputs_0      CFU response data
//   res_valid/res_ready        host result pop handshake
//   res_data                   head of the result FIFO
//   busy                       a command is in flight or still queued
//   timeout_err                sticky: some command got no response in time
//   issued_cnt                 commands completed (response or timeout), wraps
// -----------------------------------------------------------------------------
module cfu_initiator #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_function_id,
    input  logic [31:0] req_in0,
    input  logic [31:0] req_in1,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_payload_outputs_0,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] issued_cnt
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int CCW = CAW + 1;
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int CMD_W = 74;

    localparam logic [CCW-1:0] CMD_FULL      = CCW'(CMD_DEPTH);
    localparam logic [RCW-1:0] RES_FULL      = RCW'(RES_DEPTH);
    localparam logic [16:0]    TIMEOUT_LIMIT = 17'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          state_reg;
    logic            cmd_valid_reg;
    logic            rsp_ready_reg;
    logic [9:0]      fid_reg;
    logic [31:0]     in0_reg;
    logic [31:0]     in1_reg;
    logic [15:0]     tcnt_reg;
    logic            timeout_err_reg;
    logic [15:0]     issued_cnt_reg;

    logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]   cmd_wr_ptr_reg;
    logic [CAW-1:0]   cmd_rd_ptr_reg;
    logic [CCW-1:0]   cmd_count_reg;

    logic [31:0]      res_mem [RES_DEPTH];
    logic [RAW-1:0]   res_wr_ptr_reg;
    logic [RAW-1:0]   res_rd_ptr_reg;
    logic [RCW-1:0]   res_count_reg;

    // ------------------------------------------------------------------------
    // Handshake decodes
    // ------------------------------------------------------------------------
    logic             cmd_push;
    logic             cmd_pop;
    logic             res_push;
    logic             res_pop;
    logic             credit;
    logic [RCW-1:0]   res_in_flight;
    logic [16:0]      tcnt_inc;

    assign req_ready = (cmd_count_reg < CMD_FULL);
    assign cmd_push  = req_valid && req_ready;

    // A result slot is reserved for the command in flight, so a response can
    // never find the result FIFO full.
    assign res_in_flight = res_count_reg + RCW'(state_reg != IDLE);
    assign credit        = (res_in_flight < RES_FULL);
    assign cmd_pop       = (state_reg == IDLE) && (cmd_count_reg != '0) && credit;

    // rsp_ready_reg is high exactly in WAIT_RSP, so this is the response
    // handshake; responses in other states are ignored.
    assign res_push  = rsp_ready_reg && rsp_valid;
    assign res_valid = (res_count_reg != '0);
    assign res_pop   = res_valid && res_ready;

    assign tcnt_inc  = {1'b0, tcnt_reg} + 17'd1;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr_reg] <= {req_function_id, req_in0, req_in1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_wr_ptr_reg <= '0;
            cmd_rd_ptr_reg <= '0;
            cmd_count_reg  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + 1'b1;
            if (cmd_pop)  cmd_rd_ptr_reg <= cmd_rd_ptr_reg + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count_reg <= cmd_count_reg + 1'b1;
                2'b01:   cmd_count_reg <= cmd_count_reg - 1'b1;
                default: cmd_count_reg <= cmd_count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res_push) begin
            res_mem[res_wr_ptr_reg] <= rsp_payload_outputs_0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_wr_ptr_reg <= '0;
            res_rd_ptr_reg <= '0;
            res_count_reg  <= '0;
        end else begin
            if (res_push) res_wr_ptr_reg <= res_wr_ptr_reg + 1'b1;
            if (res_pop)  res_rd_ptr_reg <= res_rd_ptr_reg + 1'b1;
            case ({res_push, res_pop})
                2'b10:   res_count_reg <= res_count_reg + 1'b1;
                2'b01:   res_count_reg <= res_count_reg - 1'b1;
                default: res_count_reg <= res_count_reg;
            endcase
        end
    end

    // Storage is never reset, so mask it while the FIFO is empty.
    assign res_data = res_valid ? res_mem[res_rd_ptr_reg] : 32'd0;

    // ------------------------------------------------------------------------
    // Issue / response FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            cmd_valid_reg   <= 1'b0;
            rsp_ready_reg   <= 1'b0;
            fid_reg         <= '0;
            in0_reg         <= '0;
            in1_reg         <= '0;
            tcnt_reg        <= '0;
            timeout_err_reg <= 1'b0;
            issued_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_pop) begin
                        {fid_reg, in0_reg, in1_reg} <= cmd_mem[cmd_rd_ptr_reg];
                        cmd_valid_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        rsp_ready_reg <= 1'b1;
                        tcnt_reg      <= '0;
                        state_reg     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response arriving on the final cycle beats the timeout.
                    if (rsp_valid) begin
                        rsp_ready_reg  <= 1'b0;
                        issued_cnt_reg <= issued_cnt_reg + 16'd1;
                        state_reg      <= IDLE;
                    end else if (tcnt_inc == TIMEOUT_LIMIT) begin
                        timeout_err_reg <= 1'b1;
                        rsp_ready_reg   <= 1'b0;
                        issued_cnt_reg  <= issued_cnt_reg + 16'd1;
                        state_reg       <= IDLE;
                    end else begin
                        tcnt_reg <= tcnt_inc[15:0];
                    end
                end
                default: begin
                    cmd_valid_reg <= 1'b0;
                    rsp_ready_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_valid               = cmd_valid_reg;
    assign rsp_ready               = rsp_ready_reg;
    assign cmd_payload_function_id = fid_reg;
    assign cmd_payload_inputs_0    = in0_reg;
    assign cmd_payload_inputs_1    = in1_reg;
    assign timeout_err             = timeout_err_reg;
    assign issued_cnt              = issued_cnt_reg;
    assign busy                    = (state_reg != IDLE) || (cmd_count_reg != '0);

endmodule

// File: tb/tb_cfu_initiator.sv
// -----------------------------------------------------------------------------
// tb_cfu_initiator
//
// Directed scenarios (single op latency, backpressure, timeout tie, timeout,
// reset while waiting, credit limit) followed by a randomized run. The random
// run uses a transaction-level model: a queue of commands the host has handed
// over, a queue of expected results, and a CFU agent that answers each
// accepted command after a chosen delay (or never, forcing a timeout).
// -----------------------------------------------------------------------------
module tb_cfu_initiator;

    localparam int TMO       = 8;
    localparam int CMD_DEPTH = 4;
    localparam int RES_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_function_id;
    logic [31:0] req_in0;
    logic [31:0] req_in1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic        timeout_err;
    logic [15:0] issued_cnt;

    cfu_initiator #(
        .CMD_DEPTH(CMD_DEPTH),
        .RES_DEPTH(RES_DEPTH),
        .TIMEOUT  (TMO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_function_id        (req_function_id),
        .req_in0                (req_in0),
        .req_in1                (req_in1),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0   (cmd_payload_inputs_0),
        .cmd_payload_inputs_1   (cmd_payload_inputs_1),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_payload_outputs_0  (rsp_payload_outputs_0),
        .res_valid              (res_valid),
        .res_ready              (res_ready),
        .res_data               (res_data),
        .busy                   (busy),
        .timeout_err            (timeout_err),
        .issued_cnt             (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- model
    logic [73:0] host_q[$];
    logic [73:0] sent_q[$];
    logic [31:0] exp_res_q[$];
    bit          out_active;
    int          out_w;
    int          out_d;
    logic [31:0] out_data;
    logic [15:0] exp_issued;
    logic        exp_terr;
    int          accepts;
    bit          saw_not_ready;
    int          dmode;
    int          res_prob;
    int          pops;

    task automatic eng_init();
        host_q.delete();
        sent_q.delete();
        exp_res_q.delete();
        out_active    = 1'b0;
        out_w         = 0;
        out_d         = 0;
        out_data      = '0;
        exp_issued    = '0;
        exp_terr      = 1'b0;
        accepts       = 0;
        saw_not_ready = 1'b0;
        pops          = 0;
    endtask

    function automatic int pick_delay();
        int r;
        if (dmode == 0) return 1;
        r = int'($urandom_range(9));
        if (r < 6) return 1 + (r % 3);
        if (r < 8) return TMO;          // response on the last allowed cycle
        return TMO + 4;                 // never answered in time
    endfunction

    // One clock cycle of host, CFU agent and result consumer. Called at a
    // falling edge; returns at the next falling edge.
    task automatic eng_cycle();
        logic [73:0] c;
        bit          was_active;
        bit          acc;
        check("res_valid", res_valid, exp_res_q.size() != 0);
        if (res_valid && exp_res_q.size() != 0) check("res_data", res_data, exp_res_q[0]);
        check("issued_cnt", issued_cnt, exp_issued);
        check("timeout_err", timeout_err, exp_terr);
        if (!req_ready) saw_not_ready = 1'b1;

        if (host_q.size() != 0) begin
            req_valid = 1'b1;
            {req_function_id, req_in0, req_in1} = host_q[0];
        end else begin
            req_valid = 1'b0;
        end
        res_ready = (int'($urandom_range(99)) < res_prob);
        cmd_ready = (dmode == 0) ? 1'b1 : ($urandom_range(3) != 0);

        was_active = out_active;
        if (out_active) begin
            out_w++;
            check("rsp_ready_wait", rsp_ready, 1);
            check("cmd_valid_busy", cmd_valid, 0);
            rsp_valid = (out_w == out_d);
            rsp_payload_outputs_0 = (out_w == out_d) ? out_data : $urandom;
        end else begin
            rsp_valid = (dmode != 0) ? $urandom_range(1) : 1'b0;
            rsp_payload_outputs_0 = $urandom;
        end

        // Effects of the coming rising edge.
        if (res_valid && res_ready && exp_res_q.size() != 0) begin
            pops++;
            $display("result %0d data=0x%08h", pops, exp_res_q[0]);
            void'(exp_res_q.pop_front());
        end
        if (out_active) begin
            if (out_w == out_d) begin
                exp_res_q.push_back(out_data);
                check("res_overflow", exp_res_q.size() <= RES_DEPTH, 1);
                exp_issued++;
                out_active = 1'b0;
            end else if (out_w == TMO) begin
                exp_terr = 1'b1;
                exp_issued++;
                out_active = 1'b0;
            end
        end
        acc = cmd_valid && cmd_ready;
        if (acc && !was_active) begin
            if (sent_q.size() == 0) begin
                check("cmd_spurious", 1, 0);
            end else begin
                c = sent_q.pop_front();
                check("cmd_fid", cmd_payload_function_id, c[73:64]);
                check("cmd_in0", cmd_payload_inputs_0, c[63:32]);
                check("cmd_in1", cmd_payload_inputs_1, c[31:0]);
            end
            accepts++;
            out_active = 1'b1;
            out_w      = 0;
            out_d      = pick_delay();
            out_data   = $urandom;
        end
        if (req_valid && req_ready) sent_q.push_back(host_q.pop_front());
        tick();
    endtask

    // ------------------------------------------------------------- helpers
    task automatic clear_inputs();
        req_valid = 0; req_function_id = '0; req_in0 = '0; req_in1 = '0;
        cmd_ready = 0; rsp_valid = 0; rsp_payload_outputs_0 = '0; res_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic push_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        while (!req_ready && g < 100) begin tick(); g++; end
        check("push_ready", req_ready, 1);
        req_valid = 1'b1; req_function_id = f; req_in0 = a; req_in1 = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp_ready();
        int g = 0;
        while (!rsp_ready && g < 20) begin tick(); g++; end
        check("wait_rsp_ready", rsp_ready, 1);
    endtask

    task automatic pop_one(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_data"}, res_data, exp);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        $display("%s: popped 0x%08h", tag, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------- main
    initial begin
        int g;
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_issued_cnt", issued_cnt, 0);
        check("rst_fid", cmd_payload_function_id, 0);
        check("rst_in0", cmd_payload_inputs_0, 0);
        check("rst_in1", cmd_payload_inputs_1, 0);
        reset = 1'b1;
        tick();
        check("rst_req_ready", req_ready, 1);
        $display("reset: done");

        // Single operation and minimum latency.
        cmd_ready = 1'b1;
        push_cmd(10'h009, 32'h0102_0304, 32'h0);
        check("lat_n0_cmd_valid", cmd_valid, 0);
        check("lat_n0_busy", busy, 1);
        tick();
        check("lat_n1_cmd_valid", cmd_valid, 1);
        check("lat_n1_fid", cmd_payload_function_id, 10'h009);
        check("lat_n1_in0", cmd_payload_inputs_0, 32'h0102_0304);
        check("lat_n1_in1", cmd_payload_inputs_1, 32'h0);
        rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'h0000_0ABC;  // ignored while in ISSUE
        tick();
        check("lat_n2_cmd_valid", cmd_valid, 0);
        check("lat_n2_rsp_ready", rsp_ready, 1);
        check("lat_n2_res_valid", res_valid, 0);
        tick();
        rsp_valid = 1'b0;
        check("lat_n3_rsp_ready", rsp_ready, 0);
        check("lat_n3_issued", issued_cnt, 1);
        pop_one("single", 32'h0000_0ABC);
        check("single_empty", res_valid, 0);
        check("single_busy", busy, 0);

        // Backpressure: payload held while cmd_ready is low.
        cmd_ready = 1'b0;
        push_cmd(10'h155, 32'hDEAD_BEEF, 32'h1234_5678);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("bp_cmd_valid", cmd_valid, 1);
            check("bp_fid", cmd_payload_function_id, 10'h155);
            check("bp_in0", cmd_payload_inputs_0, 32'hDEAD_BEEF);
            check("bp_in1", cmd_payload_inputs_1, 32'h1234_5678);
            if (i < 5) tick();
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("bp_accept_cmd_valid", cmd_valid, 0);
        check("bp_accept_rsp_ready", rsp_ready, 1);
        tick();
        check("bp_single_accept", cmd_valid, 0);
        rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'h0000_0055;
        tick();
        rsp_valid = 1'b0;
        check("bp_issued", issued_cnt, 2);
        pop_one("backpressure", 32'h0000_0055);

        // Response on the final allowed cycle wins over the timeout.
        cmd_ready = 1'b1;
        push_cmd(10'h0AA, 32'h1111_1111, 32'h2222_2222);
        wait_rsp_ready();
        for (int k = 1; k < TMO; k++) begin
            check("tie_rsp_ready", rsp_ready, 1);
            tick();
        end
        rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'h0000_0077;
        tick();
        rsp_valid = 1'b0;
        check("tie_timeout_err", timeout_err, 0);
        check("tie_issued", issued_cnt, 3);
        pop_one("tie", 32'h0000_0077);

        // Timeout, then the next queued command issues.
        push_cmd(10'h101, 32'hAAAA_0001, 32'hBBBB_0001);
        push_cmd(10'h202, 32'hAAAA_0002, 32'hBBBB_0002);
        wait_rsp_ready();
        for (int k = 1; k <= TMO; k++) begin
            check("tmo_wait_err", timeout_err, 0);
            check("tmo_wait_rsp_ready", rsp_ready, 1);
            tick();
        end
        check("tmo_err", timeout_err, 1);
        check("tmo_rsp_ready", rsp_ready, 0);
        check("tmo_no_result", res_valid, 0);
        check("tmo_issued", issued_cnt, 4);
        check("tmo_idle_cmd_valid", cmd_valid, 0);
        tick();
        check("tmo_next_cmd_valid", cmd_valid, 1);
        check("tmo_next_fid", cmd_payload_function_id, 10'h202);
        check("tmo_next_in0", cmd_payload_inputs_0, 32'hAAAA_0002);
        tick();
        rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'h0000_0202;
        tick();
        rsp_valid = 1'b0;
        check("tmo_sticky", timeout_err, 1);
        check("tmo_next_issued", issued_cnt, 5);
        pop_one("timeout_next", 32'h0000_0202);

        // Reset while waiting for a response; late response is ignored.
        push_cmd(10'h3FF, 32'h5555_5555, 32'h6666_6666);
        wait_rsp_ready();
        reset = 1'b0;
        #1;
        check("rstw_rsp_ready", rsp_ready, 0);
        check("rstw_timeout_err", timeout_err, 0);
        tick();
        reset = 1'b1;
        cmd_ready = 1'b0;
        rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstw_res_valid", res_valid, 0);
            check("rstw_rsp_ready_after", rsp_ready, 0);
        end
        rsp_valid = 1'b0;
        check("rstw_issued", issued_cnt, 0);
        check("rstw_busy", busy, 0);
        check("rstw_req_ready", req_ready, 1);
        $display("reset_in_wait: done");

        // Credit limit: six commands, results never popped.
        do_reset();
        eng_init();
        dmode = 0;
        res_prob = 0;
        for (int i = 0; i < 6; i++) host_q.push_back({10'(i + 1), 32'(32'hC000 + i), 32'(i)});
        for (int i = 0; i < 40; i++) eng_cycle();
        check("credit_accepts", accepts, 4);
        check("credit_all_pushed", host_q.size(), 0);
        check("credit_req_ready_dropped", saw_not_ready, 1);
        for (int i = 0; i < 10; i++) begin
            check("credit_hold_cmd_valid", cmd_valid, 0);
            eng_cycle();
        end
        res_prob = 100;
        g = 0;
        while ((sent_q.size() != 0 || out_active || exp_res_q.size() != 0) && g < 200) begin
            eng_cycle();
            g++;
        end
        check("credit_drain", g < 200, 1);
        check("credit_accepts_final", accepts, 6);
        $display("credit: accepts=%0d", accepts);

        // Randomized run.
        do_reset();
        eng_init();
        dmode = 1;
        res_prob = 60;
        for (int i = 0; i < 150; i++) host_q.push_back({10'($urandom), 32'($urandom), 32'($urandom)});
        g = 0;
        while ((host_q.size() != 0 || sent_q.size() != 0 || out_active || exp_res_q.size() != 0) && g < 9000) begin
            eng_cycle();
            g++;
        end
        check("rand_drain", g < 9000, 1);
        clear_inputs();
        tick();
        check("rand_issued", issued_cnt, 150);
        check("rand_accepts", accepts, 150);
        check("rand_busy", busy, 0);
        check("rand_res_empty", res_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
